// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte requesters,
// the transmit arbiter and the UART transmit side.
interface uart_tx_arbiter_if;
  logic       req0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       ack1;
  logic       uart_tx_busy;
  logic       init_tx;
  logic [7:0] uart_data_in;
  logic [1:0] grant;
  logic       timeout_err;

  modport master (
    output req0, data0, req1, data1, uart_tx_busy,
    input  ack0, ack1, init_tx, uart_data_in,
    input  grant, timeout_err
  );

  modport slave (
    input  req0, data0, req1, data1, uart_tx_busy,
    output ack0, ack1, init_tx, uart_data_in,
    output grant, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter
// between two byte requesters, with a start watchdog.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    SEND,
    GAP
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last;
  logic [7:0] wd;
  logic       pick0;
  logic       pick1;

  // Winner select; a tie goes to whoever was not last.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    unique case (1'b1)
      (bus.req0 && bus.req1): begin
        pick0 = last;
        pick1 = !last;
      end
      (bus.req0 && !bus.req1): pick0 = 1'b1;
      (!bus.req0 && bus.req1): pick1 = 1'b1;
      default: ;
    endcase
  end

  // Transfer FSM; all outputs registered, pulses default low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      last             <= 1'b1;
      wd               <= '0;
      bus.ack0         <= 1'b0;
      bus.ack1         <= 1'b0;
      bus.init_tx      <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.grant        <= 2'b00;
      bus.uart_data_in <= 8'h00;
    end else begin
      bus.ack0        <= 1'b0;
      bus.ack1        <= 1'b0;
      bus.init_tx     <= 1'b0;
      bus.timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.uart_tx_busy && (pick0 || pick1)) begin
            bus.uart_data_in <= pick1 ? bus.data1 : bus.data0;
            bus.grant        <= {pick1, pick0};
            bus.ack0         <= pick0;
            bus.ack1         <= pick1;
            bus.init_tx      <= 1'b1;
            state            <= START;
          end
        end
        START: begin
          wd    <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.uart_tx_busy) begin
            state <= SEND;
          end else if (wd == WD_LAST) begin
            bus.timeout_err <= 1'b1;
            bus.grant       <= 2'b00;
            last            <= bus.grant[1];
            state           <= IDLE;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        SEND: begin
          if (!bus.uart_tx_busy) state <= GAP;
        end
        GAP: begin
          bus.grant <= 2'b00;
          last      <= bus.grant[1];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between two byte-wide requesters. It sits between the requesters and the UART core's transmit side: it takes one byte from the granted requester, loads it onto `uart_data_in`, pulses `init_tx`, and follows `uart_tx_busy` through the frame. It returns to arbitration only after the line is free. A watchdog drops the byte and flags an error if the UART never goes busy.

## Interface
- `TIMEOUT`, default 16: cycles allowed in WAIT_BUSY for `uart_tx_busy` to rise; range 2..255.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `req0` in 1: requester 0 has a byte pending; hold with `data0` stable until `ack0`.
- `data0` in 8: requester 0 byte.
- `ack0` out 1: one-cycle pulse; `data0` has been captured.
- `req1` in 1: as `req0`, for requester 1.
- `data1` in 8: as `data0`, for requester 1.
- `ack1` out 1: as `ack0`, for requester 1.
- `uart_tx_busy` in 1: UART transmitter busy flag.
- `init_tx` out 1: one-cycle start pulse to the UART.
- `uart_data_in` out 8: byte presented to the UART; holds until the next grant.
- `grant` out 2: one-hot owner, bit0 = req0; 00 when no transfer is active.
- `timeout_err` out 1: one-cycle pulse when the watchdog expires.

## Operation
- All outputs are registered. Reset values: `ack0`/`ack1`/`init_tx`/`timeout_err` = 0, `grant` = 00, `uart_data_in` = 8'h00. Internal: state IDLE, `last` = 1, watchdog count = 0.
- The FSM states are IDLE, START, WAIT_BUSY, SEND and GAP.
- IDLE
  - Arbitrates only when `uart_tx_busy` = 0 and at least one req is high.
  - If only one req is high, that requester wins.
  - If both are high, the requester not equal to `last` wins.
  - On a win: capture its data into `uart_data_in`, set `grant` one-hot, pulse its ack, set `init_tx`=1, and go to START.
  - If `uart_tx_busy` = 1 in IDLE, no grant is issued; stay in IDLE.
- START: lasts exactly one cycle with `init_tx`=1 and the ack high. Then clear both, reset the watchdog, and go to WAIT_BUSY.
- WAIT_BUSY
  - If `uart_tx_busy`=1, go to SEND.
  - Otherwise increment the watchdog.
  - When the watchdog reaches `TIMEOUT`-1 with busy still 0: pulse `timeout_err`, set `grant`=00, set `last`=owner, and go to IDLE. The byte is dropped and is not retried.
- SEND: wait for `uart_tx_busy`=0, then go to GAP.
- GAP: one cycle. Set `grant`=00, set `last`=owner, then go to IDLE.
- Requester contract: a req still high after its ack is a new byte. The earliest re-grant is in IDLE, at least 3 cycles after the ack, so a single ack is never double-sampled.
- Bytes are never reordered within one requester.
- Only the arbiter drives `init_tx`. An external busy that was not started by the arbiter simply holds it in IDLE.

## Timing
- Latency: req sampled high at edge N (IDLE, busy low) → `init_tx`, ack and `grant` are high in the cycle after edge N.
- `init_tx` width is exactly 1 cycle, once per grant.
- `uart_data_in` is valid from the `init_tx` cycle onward and stable until the next grant.
- Minimum cycles per byte: START 1 + WAIT_BUSY ≥1 + SEND ≥1 + GAP 1.
- Timeout fires `TIMEOUT` cycles after entering WAIT_BUSY. Busy rising on that same final cycle counts as success: go to SEND, no error.
- A busy pulse that rises and falls between two WAIT_BUSY samples is missed. The UART guarantees busy ≥1 frame long.
- A simultaneous req0/req1 arrival in IDLE resolves by `last`. After reset, req0 wins the first tie.
- A req that arrives while a transfer is in progress waits. It is arbitered on the first IDLE cycle with busy low.
- `rst` mid-operation:
  - Immediately forces all reset values, including `init_tx`=0 and `grant`=00.
  - A frame already inside the UART is not aborted by this block.
  - After `rst` release, no grant is issued while busy remains high.

## Test plan
- Single byte: req0=1, data0=8'h41; model busy high 5 cycles starting 2 cycles after `init_tx` → one `init_tx` pulse, `uart_data_in`=8'h41, `ack0` 1 cycle, `grant`=01 until GAP, 0 errors.
- Tie fairness: req0 and req1 held high continuously, data0=8'hA0, data1=8'hB1 → grants alternate 01,10,01,10 starting with 01; `uart_data_in` alternates A0/B1; 4 bytes → 2 acks each.
- Timeout: `TIMEOUT`=16, busy stuck at 0, req1=1 → `timeout_err` pulse exactly 16 cycles after WAIT_BUSY entry, `grant`=00, `ack1` asserted once; next grant, if req0 is also high, goes to req0.
- Busy pre-held: busy=1 and req0=1 from reset release for 10 cycles → no `init_tx`, no ack; busy falls → `init_tx` the following cycle.
- Reset mid-SEND: assert `rst` while busy=1 and `grant`=10 → all outputs at reset values the same cycle; after release with busy still 1, no grant; after busy falls, req0 wins the tie.
- Watchdog boundary: busy rises on the 16th WAIT_BUSY cycle → SEND entered, no `timeout_err`.
